// File: rtl/decode_execute_pipe_reg_if.sv
// rtl/decode_execute_pipe_reg_if.sv - decode-to-execute bundle for the ID/EX pipeline register
interface decode_execute_pipe_reg_if #(
  parameter int PAYLOAD_W = 64
);
  logic                 decode_output_valid;
  logic [5:0]           reg_rd_id;
  logic [4:0]           rs1_id;
  logic [4:0]           rs2_id;
  logic                 is_load;
  logic                 resolve;
  logic                 select_target_pc;
  logic                 squash_after_J;
  logic                 squash_after_JALR;
  logic [PAYLOAD_W-1:0] payload;
  logic                 ex_ready;
  logic                 flush;

  logic                 decode_stall;
  logic                 ex_valid;
  logic [5:0]           ex_rd_id;
  logic [4:0]           ex_rs1_id;
  logic [4:0]           ex_rs2_id;
  logic                 ex_is_load;
  logic                 ex_resolve;
  logic                 ex_select_target_pc;
  logic                 ex_squash;
  logic [PAYLOAD_W-1:0] ex_payload;

  // Driven by decode and execute stages
  modport master (
    output decode_output_valid, reg_rd_id, rs1_id, rs2_id, is_load, resolve,
           select_target_pc, squash_after_J, squash_after_JALR, payload, ex_ready, flush,
    input  decode_stall, ex_valid, ex_rd_id, ex_rs1_id, ex_rs2_id, ex_is_load, ex_resolve,
           ex_select_target_pc, ex_squash, ex_payload
  );

  // The pipeline register itself
  modport slave (
    input  decode_output_valid, reg_rd_id, rs1_id, rs2_id, is_load, resolve,
           select_target_pc, squash_after_J, squash_after_JALR, payload, ex_ready, flush,
    output decode_stall, ex_valid, ex_rd_id, ex_rs1_id, ex_rs2_id, ex_is_load, ex_resolve,
           ex_select_target_pc, ex_squash, ex_payload
  );
endinterface

// File: rtl/decode_execute_pipe_reg.sv
// rtl/decode_execute_pipe_reg.sv - ID/EX register with load-use bubble, backpressure, flush
// and saturating bubble/flush counters
module decode_execute_pipe_reg #(
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decode_execute_pipe_reg_if.slave bus,
  output logic [CNT_W-1:0]      bubble_count,
  output logic [CNT_W-1:0]      flush_count
);

  logic hazard;
  logic advance;
  logic rd_match;

  always_comb begin
    rd_match = (bus.ex_rd_id[4:0] == bus.rs1_id) || (bus.ex_rd_id[4:0] == bus.rs2_id);
    // x0 and non-writing loads never create a dependency
    hazard   = bus.decode_output_valid && bus.ex_valid && bus.ex_is_load &&
               bus.ex_rd_id[5] && (bus.ex_rd_id[4:0] != 5'd0) && rd_match;
    advance  = bus.ex_ready || !bus.ex_valid;
    bus.decode_stall = !bus.flush && (!advance || hazard);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid            <= 1'b0;
      bus.ex_rd_id            <= '0;
      bus.ex_rs1_id           <= '0;
      bus.ex_rs2_id           <= '0;
      bus.ex_is_load          <= 1'b0;
      bus.ex_resolve          <= 1'b0;
      bus.ex_select_target_pc <= 1'b0;
      bus.ex_squash           <= 1'b0;
      bus.ex_payload          <= '0;
    end else if (bus.flush || (advance && hazard)) begin
      // Flush and bubble both leave a cleared, invalid slot behind
      bus.ex_valid            <= 1'b0;
      bus.ex_rd_id            <= '0;
      bus.ex_rs1_id           <= '0;
      bus.ex_rs2_id           <= '0;
      bus.ex_is_load          <= 1'b0;
      bus.ex_resolve          <= 1'b0;
      bus.ex_select_target_pc <= 1'b0;
      bus.ex_squash           <= 1'b0;
      bus.ex_payload          <= '0;
    end else if (advance) begin
      bus.ex_valid            <= bus.decode_output_valid;
      bus.ex_rd_id            <= bus.reg_rd_id;
      bus.ex_rs1_id           <= bus.rs1_id;
      bus.ex_rs2_id           <= bus.rs2_id;
      bus.ex_is_load          <= bus.is_load;
      bus.ex_resolve          <= bus.resolve;
      bus.ex_select_target_pc <= bus.select_target_pc;
      bus.ex_squash           <= bus.squash_after_J || bus.squash_after_JALR;
      bus.ex_payload          <= bus.payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (!bus.flush && advance && hazard && !(&bubble_count))
        bubble_count <= bubble_count + 1'b1;
      if (bus.flush && bus.ex_valid && !(&flush_count))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_execute_pipe_reg.sv
// tb/tb_decode_execute_pipe_reg.sv - randomized bench for decode_execute_pipe_reg against a
// cycle-level reference model
module tb_decode_execute_pipe_reg;
  localparam int PW   = 64;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          dv;
    logic [5:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          ld;
    logic          res;
    logic          stp;
    logic          sj;
    logic          sjr;
    logic [PW-1:0] pl;
    logic          rdy;
    logic          fl;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [5:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          ld;
    logic          res;
    logic          stp;
    logic          sq;
    logic [PW-1:0] pl;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [CW-1:0] bubble_count;
  logic [CW-1:0] flush_count;

  always #5 clk = ~clk;

  decode_execute_pipe_reg_if #(.PAYLOAD_W(PW)) bus ();

  decode_execute_pipe_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .bubble_count (bubble_count),
    .flush_count  (flush_count)
  );

  int  n_vec = 0;
  int  n_err = 0;
  ex_t m_ex;
  int  m_bub;
  int  m_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic dv, input logic [5:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic ld, input logic rdy,
                             input logic fl);
    in_t v;
    v.dv  = dv;
    v.rd  = rd;
    v.rs1 = rs1;
    v.rs2 = rs2;
    v.ld  = ld;
    v.res = 1'($urandom_range(0, 1));
    v.stp = 1'($urandom_range(0, 1));
    v.sj  = 1'($urandom_range(0, 1));
    v.sjr = 1'($urandom_range(0, 1));
    v.pl  = {$urandom, $urandom};
    v.rdy = rdy;
    v.fl  = fl;
    return v;
  endfunction

  function automatic in_t rnd();
    logic [5:0] rd;
    rd[5]   = ($urandom_range(0, 3) != 0);
    rd[4:0] = 5'($urandom_range(0, 3));
    return mk(1'($urandom_range(0, 4) != 0), rd, 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
  endfunction

  task automatic check_outputs(input string pfx);
    chk({pfx, "_ex_valid"}, 64'(bus.ex_valid), 64'(m_ex.valid));
    chk({pfx, "_ex_ctl"},
        64'({bus.ex_rd_id, bus.ex_rs1_id, bus.ex_rs2_id, bus.ex_is_load, bus.ex_resolve,
             bus.ex_select_target_pc, bus.ex_squash}),
        64'({m_ex.rd, m_ex.rs1, m_ex.rs2, m_ex.ld, m_ex.res, m_ex.stp, m_ex.sq}));
    chk({pfx, "_ex_payload"}, bus.ex_payload, m_ex.pl);
    chk({pfx, "_bubble_count"}, 64'(bubble_count), 64'(m_bub));
    chk({pfx, "_flush_count"}, 64'(flush_count), 64'(m_fl));
  endtask

  // One clock: present inputs after the falling edge, check the stall, predict the next EX slot
  task automatic cyc(input in_t v);
    logic [4:0] d;
    logic       uses;
    logic       haz;
    logic       can_move;
    ex_t        nx;
    @(negedge clk);
    bus.decode_output_valid = v.dv;
    bus.reg_rd_id           = v.rd;
    bus.rs1_id              = v.rs1;
    bus.rs2_id              = v.rs2;
    bus.is_load             = v.ld;
    bus.resolve             = v.res;
    bus.select_target_pc    = v.stp;
    bus.squash_after_J      = v.sj;
    bus.squash_after_JALR   = v.sjr;
    bus.payload             = v.pl;
    bus.ex_ready            = v.rdy;
    bus.flush               = v.fl;
    #1;
    d        = m_ex.rd[4:0];
    uses     = (d == v.rs1) || (d == v.rs2);
    haz      = v.dv && m_ex.valid && m_ex.ld && m_ex.rd[5] && (d != 5'd0) && uses;
    can_move = v.rdy || !m_ex.valid;
    chk("decode_stall", 64'(bus.decode_stall), 64'(!v.fl && (!can_move || haz)));
    nx = m_ex;
    if (v.fl) begin
      if (m_ex.valid) m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
      nx = '0;
    end else if (can_move && haz) begin
      m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
      nx = '0;
    end else if (can_move) begin
      nx = '{valid: v.dv, rd: v.rd, rs1: v.rs1, rs2: v.rs2, ld: v.ld, res: v.res,
             stp: v.stp, sq: v.sj | v.sjr, pl: v.pl};
    end
    @(posedge clk);
    #1;
    m_ex = nx;
    check_outputs("cyc");
  endtask

  // Asynchronous reset landing between clock edges
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_ex  = '0;
    m_bub = 0;
    m_fl  = 0;
    check_outputs("rst");
    chk("rst_decode_stall", 64'(bus.decode_stall), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.decode_output_valid = 1'b0;
    bus.reg_rd_id           = '0;
    bus.rs1_id              = '0;
    bus.rs2_id              = '0;
    bus.is_load             = 1'b0;
    bus.resolve             = 1'b0;
    bus.select_target_pc    = 1'b0;
    bus.squash_after_J      = 1'b0;
    bus.squash_after_JALR   = 1'b0;
    bus.payload             = '0;
    bus.ex_ready            = 1'b1;
    bus.flush               = 1'b0;
    m_ex  = '0;
    m_bub = 0;
    m_fl  = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("init");
    chk("init_decode_stall", 64'(bus.decode_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load x5 then a consumer of x5: one bubble, consumer follows
    cyc(mk(1'b1, 6'h25, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0));
    cyc(mk(1'b1, 6'h23, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0));
    chk("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
    chk("lu_bubble_count", 64'(bubble_count), 64'd1);
    cyc(mk(1'b1, 6'h23, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0));
    chk("lu_consumer_rs1", 64'(bus.ex_rs1_id), 64'd5);

    // Load to x0 never stalls
    cyc(mk(1'b1, 6'h20, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0));
    cyc(mk(1'b1, 6'h21, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    chk("x0_bubble_count", 64'(bubble_count), 64'd1);
    chk("x0_consumer_valid", 64'(bus.ex_valid), 64'd1);

    // Three cycles of execute backpressure, then release
    cyc(mk(1'b1, 6'h0A, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0));
    repeat (3) cyc(mk(1'b1, 6'h0B, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0));
    chk("bp_held_rd", 64'(bus.ex_rd_id), 64'h0A);
    cyc(mk(1'b1, 6'h0B, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0));
    chk("bp_release_rd", 64'(bus.ex_rd_id), 64'h0B);

    // Flush beats backpressure and drops the incoming instruction
    cyc(mk(1'b1, 6'h0C, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1));
    chk("fl_valid", 64'(bus.ex_valid), 64'd0);
    chk("fl_count", 64'(flush_count), 64'd1);

    // Randomized traffic with occasional mid-stream resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(rnd());
    end

    // Counter saturation
    do_reset();
    for (int i = 0; i < 2 * (CMAX + 3); i++)
      cyc(mk(1'b1, 6'h25, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0));
    chk("sat_bubble_count", 64'(bubble_count), 64'(CMAX));
    for (int i = 0; i < CMAX + 3; i++) begin
      cyc(mk(1'b1, 6'h07, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0));
      cyc(mk(1'b1, 6'h08, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1));
    end
    chk("sat_flush_count", 64'(flush_count), 64'(CMAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
